// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB initiator that fronts the matmul accelerator:
//   - FSM state encoding of the APB master
//   - register offsets of the matmul slave port
//   - default wait-state timeout and a helper that sizes the timeout counter
// -----------------------------------------------------------------------------
package apb_pkg;

    // APB master transfer phases.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Matmul accelerator slave register map (byte offsets).
    localparam logic [11:0] REG_CTRL  = 12'h000;
    localparam logic [11:0] REG_OPA   = 12'h004;
    localparam logic [11:0] REG_OPB   = 12'h008;
    localparam logic [11:0] REG_FLAGS = 12'h00C;
    localparam logic [11:0] REG_SP    = 12'h010;

    // Maximum ACCESS cycles without pready before the transfer is aborted.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    // Width of the wait-state counter. A disabled timeout (0) still gets a
    // 1-bit counter so the register never collapses to zero width.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage : apb_pkg

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB initiator: converts a valid/ready register request into one APB
// SETUP/ACCESS transfer and returns read data plus error/timeout status on a
// valid/ready response channel. One transfer is outstanding at a time.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o    request handshake (ready is high only in IDLE)
//   req_write_i            1 = write, 0 = read
//   req_addr_i             byte address
//   req_wdata_i/strb_i     write data and per-element strobes
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for writes and timeouts)
//   rsp_err_o              slave error or timeout
//   rsp_timeout_o          transfer aborted because pready never came
//   psel_o .. pstrb_o      APB request signals (all registered)
//   pready_i, pslverr_i,
//   prdata_i               APB completion signals from the slave
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned MAX_DIM        = BUS_WIDTH / DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    // request channel
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [BUS_WIDTH-1:0]  req_wdata_i,
    input  logic [MAX_DIM-1:0]    req_strb_i,

    // response channel
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,

    // APB initiator port
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [MAX_DIM-1:0]    pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    // -------------------------------------------------------------------------
    // Timeout counter sizing
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_W      = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // The counter is cleared in SETUP and reads 0 in the first ACCESS cycle,
    // so reaching TIMEOUT_CYCLES-1 without pready means TIMEOUT_CYCLES ACCESS
    // cycles have elapsed.
    localparam logic [CNT_W-1:0] CNT_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    apb_state_e             state_reg,       state_next;
    logic                   psel_reg,        psel_next;
    logic                   penable_reg,     penable_next;
    logic                   pwrite_reg,      pwrite_next;
    logic [ADDR_WIDTH-1:0]  paddr_reg,       paddr_next;
    logic [BUS_WIDTH-1:0]   pwdata_reg,      pwdata_next;
    logic [MAX_DIM-1:0]     pstrb_reg,       pstrb_next;
    logic                   rsp_valid_reg,   rsp_valid_next;
    logic [BUS_WIDTH-1:0]   rsp_rdata_reg,   rsp_rdata_next;
    logic                   rsp_err_reg,     rsp_err_next;
    logic                   rsp_timeout_reg, rsp_timeout_next;
    logic [CNT_W-1:0]       cnt_reg,         cnt_next;

    // -------------------------------------------------------------------------
    // State register. Reset is asynchronous so a reset in the middle of a
    // transfer releases the bus immediately; the in-flight response is lost.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            pstrb_reg       <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            pstrb_reg       <= pstrb_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
            cnt_reg         <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // hold everything unless a phase below changes it
        state_next       = state_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        pstrb_next       = pstrb_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        cnt_next         = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    pwrite_next  = req_write_i;
                    paddr_next   = req_addr_i;
                    pwdata_next  = req_wdata_i;
                    // strobes carry no meaning on reads; keep them quiet
                    pstrb_next   = req_write_i ? req_strb_i : '0;
                    psel_next    = 1'b1;
                    penable_next = 1'b0;
                    state_next   = SETUP;
                end
            end

            SETUP: begin
                penable_next = 1'b1;
                cnt_next     = '0;
                state_next   = ACCESS;
            end

            ACCESS: begin
                if (pready_i) begin
                    // normal completion; also wins over a same-cycle timeout
                    rsp_rdata_next   = pwrite_reg ? '0 : prdata_i;
                    rsp_err_next     = pslverr_i;
                    rsp_timeout_next = 1'b0;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
                    // hung slave: abandon the transfer and report it
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                // unreachable encoding: park safely with the bus released
                state_next     = IDLE;
                psel_next      = 1'b0;
                penable_next   = 1'b0;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready_o   = (state_reg == IDLE);

    assign psel_o        = psel_reg;
    assign penable_o     = penable_reg;
    assign pwrite_o      = pwrite_reg;
    assign paddr_o       = paddr_reg;
    assign pwdata_o      = pwdata_reg;
    assign pstrb_o       = pstrb_reg;

    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_rdata_o   = rsp_rdata_reg;
    assign rsp_err_o     = rsp_err_reg;
    assign rsp_timeout_o = rsp_timeout_reg;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master. Stimulus pushes the hand-computed response
// into a queue; a monitor pops and compares on every response handshake.
// A behavioural slave answers with a programmable number of wait states and
// records how long psel/penable stayed high and whether the request fields
// stayed stable.
// -----------------------------------------------------------------------------
module tb_apb_master;
    import apb_pkg::*;

    localparam int BW = 8;
    localparam int AW = 12;
    localparam int SW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [BW-1:0] req_wdata_i = '0;
    logic [SW-1:0] req_strb_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b1;
    logic [BW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [BW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready_i = 1'b0;
    logic          pslverr_i = 1'b0;
    logic [BW-1:0] prdata_i = '0;

    apb_master #(
        .BUS_WIDTH      (8),
        .DATA_WIDTH     (4),
        .ADDR_WIDTH     (12),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_strb_i    (req_strb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i),
        .prdata_i      (prdata_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int issued   = 0;
    int rsp_seen = 0;

    typedef struct packed {
        logic [BW-1:0] rdata;
        logic          err;
        logic          to;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- slave model ----------------
    int            s_wait = 0;        // ACCESS cycles with pready=0 before pready=1
    logic [BW-1:0] s_rdata = '0;
    logic          s_err = 1'b0;
    logic          s_noise = 1'b0;    // drive junk err/data while not ready
    logic          s_always_ready = 1'b0;
    int            acc_cnt = 0;

    int            psel_cycles = 0;
    int            pen_cycles = 0;
    logic          fields_unstable = 1'b0;
    logic [AW+BW+SW:0] fields0 = '0;
    logic          pwrite_seen = 1'b0;
    logic [BW-1:0] pwdata_seen = '0;
    logic [SW-1:0] pstrb_seen = '0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            acc_cnt   = 0;
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
        end else begin
            if (psel_o && penable_o) begin
                acc_cnt++;
                pready_i  = (acc_cnt > s_wait);
                pslverr_i = pready_i ? s_err : s_noise;
                prdata_i  = (pready_i || !s_noise) ? s_rdata : 8'hFF;
            end else begin
                acc_cnt   = 0;
                pready_i  = s_always_ready;
                pslverr_i = s_noise;
                prdata_i  = 8'h77;
            end
            if (psel_o) begin
                psel_cycles++;
                if (penable_o) pen_cycles++;
                if (psel_cycles == 1) fields0 = {pwrite_o, paddr_o, pwdata_o, pstrb_o};
                else if (fields0 != {pwrite_o, paddr_o, pwdata_o, pstrb_o}) fields_unstable = 1'b1;
                pwrite_seen = pwrite_o;
                pwdata_seen = pwdata_o;
                pstrb_seen  = pstrb_o;
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            $display("txn %0d: rdata=0x%02h err=%0b timeout=%0b",
                     rsp_seen, rsp_rdata_o, rsp_err_o, rsp_timeout_o);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata",   32'(rsp_rdata_o),   32'(e.rdata));
                chk("rsp_err",     32'(rsp_err_o),     32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
            end
            rsp_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge.
    task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                             input logic [SW-1:0] s, input int wt, input logic [BW-1:0] rd,
                             input logic er, input logic noise,
                             input logic [BW-1:0] e_rd, input logic e_err, input logic e_to);
        exp_t e;
        s_wait = wt; s_rdata = rd; s_err = er; s_noise = noise;
        s_always_ready = (wt == 0);
        psel_cycles = 0; pen_cycles = 0; fields_unstable = 1'b0;
        e.rdata = e_rd; e.err = e_err; e.to = e_to;
        exp_q.push_back(e);
        issued++;
        req_write_i = w; req_addr_i = a; req_wdata_i = d; req_strb_i = s;
        req_valid_i = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin ok = 1; break; end
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i);
            if (rsp_seen >= issued) begin ok = 1; break; end
        end
        #1;
        if (!ok) chk("rsp_wait_timeout", 32'(rsp_seen), 32'(issued));
    endtask

    task automatic check_stats(input string tag, input int ps, input int pe, input logic w,
                               input logic [BW-1:0] d, input logic [SW-1:0] s);
        chk({tag, "_psel_cycles"},    32'(psel_cycles),     32'(ps));
        chk({tag, "_penable_cycles"}, 32'(pen_cycles),      32'(pe));
        chk({tag, "_fields_stable"},  32'(fields_unstable), 32'd0);
        chk({tag, "_pwrite"},         32'(pwrite_seen),     32'(w));
        chk({tag, "_pstrb"},          32'(pstrb_seen),      32'(s));
        if (w) chk({tag, "_pwdata"},  32'(pwdata_seen),     32'(d));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        #12;
        chk("reset_psel",      32'(psel_o),      32'd0);
        chk("reset_penable",   32'(penable_o),   32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_paddr",     32'(paddr_o),     32'd0);
        chk("reset_req_ready", 32'(req_ready_o), 32'd1);
        #8 rst_ni = 1'b1;                              // released at a falling edge
        @(posedge clk_i); #1;

        // 1. write, no wait states
        drive_req(1'b1, REG_OPA, 8'h5A, 2'b11, 0, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_accept(); wait_rsp();
        check_stats("wr_nowait", 2, 1, 1'b1, 8'h5A, 2'b11);

        // 2. read, 3 wait states, junk err/data while waiting
        drive_req(1'b0, REG_SP, 8'h11, 2'b11, 3, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        wait_accept(); wait_rsp();
        check_stats("rd_wait3", 5, 4, 1'b0, 8'h00, 2'b00);

        // 3. slave error on write
        drive_req(1'b1, REG_CTRL, 8'h01, 2'b01, 1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_accept(); wait_rsp();
        check_stats("wr_slverr", 3, 2, 1'b1, 8'h01, 2'b01);

        // 4. hung slave: timeout after 16 ACCESS cycles
        drive_req(1'b0, REG_OPB, 8'h00, 2'b00, 1000, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_accept(); wait_rsp();
        check_stats("rd_timeout", 17, 16, 1'b0, 8'h00, 2'b00);

        // 5. pready on the 16th ACCESS cycle: normal completion
        drive_req(1'b0, REG_FLAGS, 8'h00, 2'b00, 15, 8'h5C, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0);
        wait_accept(); wait_rsp();
        check_stats("rd_edge16", 17, 16, 1'b0, 8'h00, 2'b00);

        // 6. write with all strobes off goes out unchanged
        drive_req(1'b1, REG_CTRL, 8'h3F, 2'b00, 0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_accept(); wait_rsp();
        check_stats("wr_strb0", 2, 1, 1'b1, 8'h3F, 2'b00);

        // 7. response backpressure, then back-to-back request
        rsp_ready_i = 1'b0;
        drive_req(1'b1, REG_SP, 8'h96, 2'b10, 0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_accept();
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_i);
                if (rsp_valid_o) begin seen = 1; break; end
            end
            if (!seen) chk("bp_rsp_valid_timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk_i);
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_rsp_rdata", 32'(rsp_rdata_o), 32'd0);
            chk("bp_rsp_err",   32'(rsp_err_o),   32'd0);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
            chk("bp_psel",      32'(psel_o),      32'd0);
        end
        check_stats("wr_bp", 2, 1, 1'b1, 8'h96, 2'b10);
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        drive_req(1'b0, REG_FLAGS, 8'h00, 2'b00, 0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("bp_still_busy", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        chk("bp_ready_next", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        wait_rsp();
        check_stats("rd_b2b", 2, 1, 1'b0, 8'h00, 2'b00);

        // 8. reset in the middle of ACCESS
        drive_req(1'b0, REG_OPB, 8'h00, 2'b00, 1000, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wait_accept();
        begin
            bit seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_i);
                if (penable_o) begin seen = 1; break; end
            end
            if (!seen) chk("rst_penable_timeout", 32'd0, 32'd1);
        end
        @(negedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_psel",      32'(psel_o),      32'd0);
        chk("rst_mid_penable",   32'(penable_o),   32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
        exp_q.delete();
        issued = rsp_seen;
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_rel_req_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        drive_req(1'b0, REG_FLAGS, 8'h00, 2'b00, 1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        wait_accept(); wait_rsp();
        check_stats("rd_after_rst", 3, 2, 1'b0, 8'h00, 2'b00);
        chk("rsp_count", 32'(rsp_seen), 32'(issued));

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apb_master

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns simple valid/ready register requests into APB SETUP/ACCESS transfers and returns read data and error status.
- Drives the matmul accelerator's slave port (control register, operand A/B, scratchpad, flags) from a bench sequencer or a host-side controller.
- Handles exactly one outstanding transfer.
- Adds a wait-state timeout so a hung slave cannot stall the requester.

Parameters:
- BUS_WIDTH, 8, APB data width (pwdata/prdata).
- DATA_WIDTH, 4, matrix element width; sets strobe width.
- ADDR_WIDTH, 12, APB address width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, strobe width (one bit per element lane).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  BUS_WIDTH  write data.
- req_strb_i  in  MAX_DIM  write strobes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  BUS_WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  pslverr or timeout.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  BUS_WIDTH  APB write data.
- pstrb_o  out  MAX_DIM  APB strobes.
- pready_i  in  1  slave ready.
- pslverr_i  in  1  slave error.
- prdata_i  in  BUS_WIDTH  slave read data.

Behaviour:
- All outputs are registered.
- Reset is asynchronous. It forces state=IDLE and drives to 0: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o, and the timeout counter.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1 (combinational from state; it is the only non-registered output).
  - On req_valid_i: latch write/addr/wdata/strb into the p* outputs, set psel_o=1 and penable_o=0, go to SETUP.
  - pstrb_o is forced to 0 on reads.
- SETUP (exactly 1 cycle): set penable_o=1, clear the counter, go to ACCESS.
- ACCESS:
  - psel_o=penable_o=1; paddr/pwrite/pwdata/pstrb are held stable.
  - The counter increments every cycle in which pready_i=0.
  - If pready_i=1: capture rsp_rdata_o = prdata_i for reads or 0 for writes; rsp_err_o = pslverr_i; rsp_timeout_o = 0. Drop psel_o and penable_o, set rsp_valid_o=1, go to RESP.
  - If pready_i=0, TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: drop psel_o and penable_o; respond with rdata=0, err=1, timeout=1; go to RESP.
  - pready_i and timeout in the same cycle: pready wins (normal completion).
- RESP:
  - rsp_valid_o is held with its data stable until rsp_ready_i=1; then clear rsp_valid_o and go to IDLE.
  - No new request is accepted in RESP.
- Latency: minimum 2 APB cycles (SETUP + one ACCESS). rsp_valid_o asserts the cycle after the pready_i sample. Request acceptance to the next req_ready_o is at least 4 cycles.
- pslverr_i and prdata_i are ignored outside ACCESS-with-pready.
- Write strobes are passed through unchanged. A write with strb=0 is issued as-is; the slave decides whether it is an error.
- Reset asserted mid-transfer drops psel_o and penable_o immediately (asynchronously). The response is lost; there is no replay.
- An illegal state encoding recovers to IDLE with all APB outputs low.

Decomposition:
- Shared package apb_pkg holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - matmul register offsets: CTRL 0x00, OPA 0x04, OPB 0x08, SP 0x10, FLAGS 0x0C;
  - the default TIMEOUT_CYCLES.
- Single module; no sub-module is warranted. The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits.

Test Plan:
- Write, no wait states: addr=0x004, wdata=0x5A, strb=2'b11, slave holds pready=1. Expect psel high 2 cycles, penable high in cycle 2 only, rsp_valid the next cycle with err=0, rdata=0.
- Read with 3 wait states: addr=0x010, pready rises on the 4th ACCESS cycle with prdata=0xC3. Expect paddr stable throughout, pstrb=0, rsp_rdata=0xC3, err=0, timeout=0.
- Slave error: write to 0x000 with pslverr=1 at pready. Expect rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=16 and pready held 0. Expect psel/penable to drop after exactly 16 ACCESS cycles, then rsp err=1, timeout=1, rdata=0. Repeat with pready rising on cycle 16 and expect a normal completion.
- Response backpressure: rsp_ready=0 for 5 cycles after completion. Expect rsp_valid and data stable, req_ready=0, psel=0 throughout; accept the next request one cycle after rsp_ready.
- Reset mid-ACCESS: assert rst_ni=0 between clock edges. Expect psel/penable/rsp_valid to go 0 immediately. After release, req_ready=1 and a subsequent read of 0x00C completes normally.
